vme_bus_arbiter: RTL and testbench

//  Two-requester arbiter sharing one cheby-generated register slave (VMEAddr/VMERdMem/VMEWrMem/VMERdDone/VMEWrDone bus).

---
 rtl/vme_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_bus_arbiter.sv
// rtl/vme_bus_arbiter.sv - round-robin two-requester arbiter for a cheby register slave
//
// Requester A (host VME bridge) and requester B (local sequencer) post level
// requests. One is granted round-robin. A one-cycle read or write strobe goes
// to the slave, and the arbiter waits for the matching Done. The owner then
// gets a one-cycle done pulse, with read data on reads.
//
// Optional feature: define VME_BUS_ARBITER_TIMEOUT_EN to add a WAIT watchdog.
// After TIMEOUT cycles with no matching Done, the access completes with err=1
// and, on reads, rdata of all ones.
//
// Ports:
//   Clk, rst_n                  clock, asynchronous active-low reset
//   a_rd/a_wr/a_addr/a_wdata    requester A level request, word address, write data
//   a_rdata/a_done/a_err        requester A read data, completion pulse, timeout flag
//   b_*                         same set for requester B
//   VMEAddr/VMEWrData           slave address [AW:1] and write data (hold between accesses)
//   VMERdMem/VMEWrMem           slave one-cycle read/write strobes
//   VMERdData/VMERdDone         slave read data and read acknowledge
//   VMEWrDone                   slave write acknowledge
//   busy                        high while an access is in flight (ISSUE/WAIT/DONE)
module vme_bus_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic          a_rd,
    input  logic          a_wr,
    input  logic [AW:1]   a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_done,
    output logic          a_err,
    input  logic          b_rd,
    input  logic          b_wr,
    input  logic [AW:1]   b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata,
    output logic          b_done,
    output logic          b_err,
    output logic [AW:1]   VMEAddr,
    output logic [DW-1:0] VMEWrData,
    output logic          VMERdMem,
    output logic          VMEWrMem,
    input  logic [DW-1:0] VMERdData,
    input  logic          VMERdDone,
    input  logic          VMEWrDone,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_last_b;     // last completed access belonged to B
    logic          r_own_b;      // current owner is B
    logic          r_op_rd;      // current access is a read
    logic [AW:1]   r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_rdmem;
    logic          r_wrmem;
    logic          r_a_done;
    logic          r_b_done;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          r_busy;

    logic          w_req_a;
    logic          w_req_b;
    logic          w_pick_b;
    logic          w_pick_rd;
    logic          w_match;
    logic          w_timeout;
    logic          w_finish;
    logic          w_grant;
    logic          w_cmpl;
    logic          w_rdmem_nxt;
    logic          w_wrmem_nxt;
    logic          w_a_done_nxt;
    logic          w_b_done_nxt;
    logic          w_busy_nxt;
    logic [DW-1:0] w_rdata_nxt;

    assign w_req_a   = a_rd | a_wr;
    assign w_req_b   = b_rd | b_wr;
    // B wins only when A is idle or A was served last; reset leaves r_last_b=1
    // so A wins the first tie.
    assign w_pick_b  = w_req_b & (~w_req_a | ~r_last_b);
    // rd takes precedence over wr from the same requester.
    assign w_pick_rd = w_pick_b ? b_rd : a_rd;
    // Only the Done that matches the operation in flight completes it.
    assign w_match   = r_op_rd ? VMERdDone : VMEWrDone;
    assign w_finish  = w_match | w_timeout;

    // State register
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_a | w_req_b) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_finish) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, so that each
    // output lines up with the state it belongs to.
    always_comb begin
        w_grant      = (r_state == S_IDLE) & (w_req_a | w_req_b);
        w_rdmem_nxt  = w_grant & w_pick_rd;
        w_wrmem_nxt  = w_grant & ~w_pick_rd;
        w_cmpl       = (r_state == S_WAIT) & w_finish;
        w_a_done_nxt = w_cmpl & ~r_own_b;
        w_b_done_nxt = w_cmpl & r_own_b;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        // A Done in the same cycle as the watchdog wins and returns real data.
        w_rdata_nxt  = w_match ? VMERdData : {DW{1'b1}};
    end

    // Registered outputs and the per-access latch
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b  <= 1'b1;
            r_own_b   <= 1'b0;
            r_op_rd   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdmem   <= 1'b0;
            r_wrmem   <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_rdmem  <= w_rdmem_nxt;
            r_wrmem  <= w_wrmem_nxt;
            r_a_done <= w_a_done_nxt;
            r_b_done <= w_b_done_nxt;
            r_busy   <= w_busy_nxt;
            if (w_grant) begin
                r_own_b <= w_pick_b;
                r_op_rd <= w_pick_rd;
                r_addr  <= w_pick_b ? b_addr : a_addr;
                r_wdata <= w_pick_b ? b_wdata : a_wdata;
            end
            if (w_cmpl & r_op_rd) begin
                if (r_own_b) begin
                    r_b_rdata <= w_rdata_nxt;
                end else begin
                    r_a_rdata <= w_rdata_nxt;
                end
            end
            if (r_state == S_DONE) begin
                r_last_b <= r_own_b;
            end
        end
    end

`ifdef VME_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

    logic [15:0] r_cnt;
    logic        r_a_err;
    logic        r_b_err;

    // Cleared outside WAIT, so it reads 0 on the first WAIT cycle.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_WAIT) & (r_cnt == TO_VAL);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_err <= 1'b0;
            r_b_err <= 1'b0;
        end else begin
            r_a_err <= w_a_done_nxt & ~w_match;
            r_b_err <= w_b_done_nxt & ~w_match;
        end
    end

    assign a_err = r_a_err;
    assign b_err = r_b_err;
`else
    assign w_timeout = 1'b0;
    assign a_err     = 1'b0;
    assign b_err     = 1'b0;
`endif

    assign a_rdata   = r_a_rdata;
    assign a_done    = r_a_done;
    assign b_rdata   = r_b_rdata;
    assign b_done    = r_b_done;
    assign VMEAddr   = r_addr;
    assign VMEWrData = r_wdata;
    assign VMERdMem  = r_rdmem;
    assign VMEWrMem  = r_wrmem;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// tb/tb_vme_bus_arbiter.sv - scoreboard bench for vme_bus_arbiter
module tb_vme_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          Clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [AW:1]   a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          a_done, b_done, a_err, b_err;
    logic [AW:1]   VMEAddr;
    logic [DW-1:0] VMEWrData;
    logic          VMERdMem, VMEWrMem;
    logic [DW-1:0] VMERdData = '0;
    logic          VMERdDone = 1'b0, VMEWrDone = 1'b0;
    logic          busy;

    vme_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done), .a_err(a_err),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done), .b_err(b_err),
        .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
        .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          rd;
        logic [AW:1]   addr;
        logic [DW-1:0] data;
    } strb_t;

    typedef struct packed {
        logic          chk_data;
        logic [DW-1:0] rdata;
        logic          err;
    } done_t;

    strb_t sq[$];
    done_t aq[$];
    done_t bq[$];
    strb_t m_s;
    done_t m_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_strobe = 0, t_adone = 0, t_bdone = 0;
    int done_cnt = 0;

    logic [DW-1:0] mem [256];
    bit            slave_on = 1'b1;
    bit            spur = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_strobe(input logic rd, input logic [AW:1] addr, input logic [DW-1:0] data);
        strb_t s;
        s.rd = rd;
        s.addr = addr;
        s.data = data;
        sq.push_back(s);
    endtask

    // Slave model: acks one cycle after the strobe; optionally sends a stray
    // VMEWrDone first during reads.
    initial begin
        logic        s_rd;
        logic [AW:1] s_addr;
        forever begin
            @(posedge Clk); #1;
            VMERdDone = 1'b0;
            VMEWrDone = 1'b0;
            if (slave_on && (VMERdMem || VMEWrMem)) begin
                s_rd = VMERdMem;
                s_addr = VMEAddr;
                if (spur && s_rd) begin
                    @(posedge Clk); #1; VMEWrDone = 1'b1;
                    @(posedge Clk); #1; VMEWrDone = 1'b0;
                end
                @(posedge Clk); #1;
                if (s_rd) begin
                    VMERdDone = 1'b1;
                    VMERdData = mem[s_addr];
                end else begin
                    VMEWrDone = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge Clk) begin
        if (rst_n) begin
            if (VMERdMem || VMEWrMem) begin
                t_strobe = cyc;
                if (sq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL strobe_unexpected: rd=%0b wr=%0b addr=%0h", VMERdMem, VMEWrMem, VMEAddr);
                end else begin
                    m_s = sq.pop_front();
                    chk("strobe_kind", {30'd0, VMERdMem, VMEWrMem}, {30'd0, m_s.rd, ~m_s.rd});
                    chk("strobe_addr", VMEAddr, m_s.addr);
                    if (!m_s.rd) chk("strobe_wdata", VMEWrData, m_s.data);
                end
            end
            if (a_done) begin
                t_adone = cyc;
                done_cnt++;
                if (aq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_done_unexpected: rdata=%0h", a_rdata);
                end else begin
                    m_e = aq.pop_front();
                    chk("a_err", a_err, m_e.err);
                    if (m_e.chk_data) chk("a_rdata", a_rdata, m_e.rdata);
                end
            end
            if (b_done) begin
                t_bdone = cyc;
                done_cnt++;
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_done_unexpected: rdata=%0h", b_rdata);
                end else begin
                    m_e = bq.pop_front();
                    chk("b_err", b_err, m_e.err);
                    if (m_e.chk_data) chk("b_rdata", b_rdata, m_e.rdata);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        repeat (3) @(posedge Clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic req(input bit is_b, input bit rd, input bit wr, input logic [AW:1] addr,
                       input logic [DW-1:0] wd, input bit chk_data, input logic [DW-1:0] exp_rdata,
                       input bit exp_err, output int t_raise);
        done_t e;
        bit    seen;
        e.chk_data = chk_data;
        e.rdata = exp_rdata;
        e.err = exp_err;
        if (is_b) bq.push_back(e); else aq.push_back(e);
        @(posedge Clk); #1;
        t_raise = cyc;
        if (is_b) begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd; end
        else begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd; end
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge Clk);
            seen = is_b ? b_done : a_done;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_done_wait: no done within 300 cycles", is_b ? "b" : "a");
        end
        #1;
        if (is_b) begin b_rd = 0; b_wr = 0; end else begin a_rd = 0; a_wr = 0; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int tr, tra, trb, n_before;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[2] = 16'h1234;
        mem[3] = 16'hBEEF;

        do_reset();
        chk("rst_strobes", {VMERdMem, VMEWrMem}, 0);
        chk("rst_addr", VMEAddr, 0);
        chk("rst_wdata", VMEWrData, 0);
        chk("rst_done", {a_done, b_done}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_err", {a_err, b_err}, 0);
        chk("rst_busy", busy, 0);

        // single A read
        exp_strobe(1'b1, 8'h02, 16'h0);
        req(0, 1, 0, 8'h02, 16'h0, 1, 16'h1234, 0, tr);
        chk("t1_req_to_strobe", t_strobe - tr, 1);
        chk("t1_strobe_to_done", t_adone - t_strobe, 2);

        // simultaneous writes after reset: A first
        do_reset();
        exp_strobe(1'b0, 8'h01, 16'h0011);
        exp_strobe(1'b0, 8'h02, 16'h0022);
        fork
            req(0, 0, 1, 8'h01, 16'h0011, 0, 16'h0, 0, tra);
            req(1, 0, 1, 8'h02, 16'h0022, 0, 16'h0, 0, trb);
        join
        chk("t2_a_before_b", {31'd0, (t_adone < t_bdone)}, 1);

        // six contended accesses alternate A,B,A,B,A,B
        for (int i = 0; i < 3; i++) begin
            exp_strobe(1'b0, 8'h10, 16'h00A0 + 16'(i));
            exp_strobe(1'b0, 8'h20, 16'h00B0 + 16'(i));
        end
        fork
            begin
                for (int i = 0; i < 3; i++) req(0, 0, 1, 8'h10, 16'h00A0 + 16'(i), 0, 16'h0, 0, tra);
            end
            begin
                for (int j = 0; j < 3; j++) req(1, 0, 1, 8'h20, 16'h00B0 + 16'(j), 0, 16'h0, 0, trb);
            end
        join

        // B rd+wr together: read only
        exp_strobe(1'b1, 8'h03, 16'h0);
        req(1, 1, 1, 8'h03, 16'h5555, 1, 16'hBEEF, 0, tr);

        // stray VMEWrDone during a read is ignored
        spur = 1'b1;
        exp_strobe(1'b1, 8'h02, 16'h0);
        req(0, 1, 0, 8'h02, 16'h0, 1, 16'h1234, 0, tr);
        spur = 1'b0;
        chk("t5_spurious_latency", t_adone - t_strobe, 4);

        slave_on = 1'b0;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
        // watchdog abort on a read the slave never acks
        exp_strobe(1'b1, 8'h05, 16'h0);
        req(0, 1, 0, 8'h05, 16'h0, 1, 16'hFFFF, 1, tr);
        chk("t6_timeout_latency", t_adone - t_strobe, 10);
`endif

        // reset in the middle of WAIT
        exp_strobe(1'b1, 8'h07, 16'h0);
        @(posedge Clk); #1;
        a_rd = 1'b1; a_addr = 8'h07;
        repeat (4) @(negedge Clk);
        chk("mid_busy_before", busy, 1);
        chk("mid_addr_before", VMEAddr, 8'h07);
        n_before = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {VMERdMem, VMEWrMem}, 0);
        chk("mid_rst_addr", VMEAddr, 0);
        chk("mid_rst_done", {a_done, b_done}, 0);
        chk("mid_rst_a_rdata", a_rdata, 0);
        chk("mid_rst_err", {a_err, b_err}, 0);
        chk("mid_rst_busy", busy, 0);
        a_rd = 1'b0;
        repeat (2) @(posedge Clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge Clk);
        chk("mid_no_done", done_cnt, n_before);
        chk("mid_idle_busy", busy, 0);

        chk("sq_empty", sq.size(), 0);
        chk("aq_empty", aq.size(), 0);
        chk("bq_empty", bq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
